// File: rtl/tx_char_fifo.sv
// tx_char_fifo: CPU-to-display character buffer behind the DSP/DSPCR
// register pair. Shows busy while full, drains over valid/ready, and latches
// a sticky overflow flag when a write is dropped.
module tx_char_fifo #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic       clk25,
  input  logic       rst,
  input  logic       enable,
  input  logic       address,
  input  logic       w_en,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic [6:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overflow
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [6:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;

  logic full_c;
  logic empty_c;
  logic push_c;
  logic push_ok_c;
  logic pop_c;
  logic ctrl_wr_c;

  assign full_c    = (count_q == CNT_W'(DEPTH));
  assign empty_c   = (count_q == '0);
  assign push_c    = enable & w_en & ~address;
  assign ctrl_wr_c = enable & w_en & address;
  assign push_ok_c = push_c & ~full_c;
  assign pop_c     = ~empty_c & out_ready;

  assign out_valid = ~empty_c;
  assign out_data  = mem_q[rd_ptr_q];
  assign overflow  = overflow_q;

  // Next-state for pointers, occupancy and the sticky overflow flag
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push_ok_c) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (push_c && full_c) begin
      overflow_d = 1'b1;
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end

    if (push_ok_c && !pop_c) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_c && !push_ok_c) begin
      count_d = count_q - CNT_W'(1);
    end

    // Flush wins over any pop happening in the same cycle
    if (ctrl_wr_c) begin
      if (din[0]) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end
      if (din[7]) begin
        overflow_d = 1'b0;
      end
    end
  end

  // State registers, emptied immediately on reset
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Character storage; contents are never observed while empty, so no reset
  always_ff @(posedge clk25) begin
    if (push_ok_c) begin
      mem_q[wr_ptr_q] <= din[6:0];
    end
  end

  // Bus read mux: busy bit at DSP, overflow and occupancy at DSPCR
  always_comb begin
    dout = 8'h00;
    if (enable && !w_en) begin
      if (address) begin
        dout = {overflow_q, 2'b00, 5'(count_q)};
      end else begin
        dout = {full_c, 7'b0000000};
      end
    end
  end

endmodule

// File: tb/tb_tx_char_fifo.sv
// Bench for tx_char_fifo: directed scenarios plus a randomized run, all
// checked against a queue-based model of the character buffer.
module tb_tx_char_fifo;

  localparam int DEPTH = 16;

  logic       clk25;
  logic       rst;
  logic       enable;
  logic       address;
  logic       w_en;
  logic [7:0] din;
  logic [7:0] dout;
  logic [6:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] mq [$];
  logic       m_ovf = 1'b0;

  tx_char_fifo #(.ADDR_W(4)) dut (
    .clk25     (clk25),
    .rst       (rst),
    .enable    (enable),
    .address   (address),
    .w_en      (w_en),
    .din       (din),
    .dout      (dout),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow)
  );

  initial clk25 = 1'b0;
  always #20 clk25 = ~clk25;

  task automatic drive(input logic en, input logic adr, input logic we,
                       input logic [7:0] d, input logic rdy);
    enable    = en;
    address   = adr;
    w_en      = we;
    din       = d;
    out_ready = rdy;
  endtask

  // One clock edge; the model consumes the inputs present at the edge
  task automatic tick();
    int   pre;
    logic pop_m, push_m, ctl_m;
    logic [7:0] d;
    pre    = mq.size();
    pop_m  = out_ready && (pre != 0);
    push_m = enable && w_en && !address;
    ctl_m  = enable && w_en && address;
    d      = din;
    @(posedge clk25);
    #1;
    if (ctl_m && d[0]) begin
      mq.delete();
    end else begin
      if (pop_m) void'(mq.pop_front());
      if (push_m) begin
        if (pre < DEPTH) mq.push_back(d[6:0]);
        else m_ovf = 1'b1;
      end
    end
    if (ctl_m && d[7]) m_ovf = 1'b0;
  endtask

  // Non-clocked register read; restores the previous bus inputs
  task automatic rd(input logic adr, output logic [7:0] val);
    logic s_en, s_adr, s_we;
    s_en = enable; s_adr = address; s_we = w_en;
    enable = 1'b1; address = adr; w_en = 1'b0;
    #1;
    val = dout;
    enable = s_en; address = s_adr; w_en = s_we;
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst = 1'b1;
    drive(0, 0, 0, 8'h00, 0);
    repeat (3) @(posedge clk25);
    #7 rst = 1'b0;
    mq.delete(); m_ovf = 1'b0;
    rd(0, v);
    n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL reset_dsp got %h want 00", v); end
    rd(1, v);
    n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL reset_dspcr got %h want 00", v); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", overflow); end
    drive(0, 0, 0, 8'h00, 0);
    n_tests++; if (dout !== 8'h00) begin n_fail++; $display("FAIL idle_dout got %h want 00", dout); end
  endtask

  task automatic test_single();
    logic [7:0] v;
    drive(1, 0, 1, 8'hC1, 0);
    tick();
    drive(0, 0, 0, 8'h00, 0);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", out_valid); end
    n_tests++; if (out_data !== 7'h41) begin n_fail++; $display("FAIL single_data got %h want 41", out_data); end
    rd(1, v);
    n_tests++; if (v !== 8'h01) begin n_fail++; $display("FAIL single_count got %h want 01", v); end
    drive(0, 0, 0, 8'h00, 1);
    tick();
    drive(0, 0, 0, 8'h00, 0);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop_valid got %b want 0", out_valid); end
    rd(1, v);
    n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL single_pop_count got %h want 00", v); end
  endtask

  task automatic test_full();
    logic [7:0] v;
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 1, 8'(8'h30 + i), 0);
      tick();
    end
    drive(0, 0, 0, 8'h00, 0);
    rd(0, v);
    n_tests++; if (v !== 8'h80) begin n_fail++; $display("FAIL full_busy got %h want 80", v); end
    rd(1, v);
    n_tests++; if (v !== 8'h10) begin n_fail++; $display("FAIL full_count got %h want 10", v); end
    // A pop in the same cycle must not rescue the dropped write
    drive(1, 0, 1, 8'h5A, 1);
    tick();
    drive(0, 0, 0, 8'h00, 0);
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL full_ovf got %b want 1", overflow); end
    rd(1, v);
    n_tests++; if (v !== 8'h8F) begin n_fail++; $display("FAIL full_ovf_status got %h want 8f", v); end
    for (int i = 1; i < 16; i++) begin
      n_tests++;
      if (out_data !== 7'(8'h30 + i) || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL drain_%0d got %h/%b want %h/1", i, out_data, out_valid, 7'(8'h30 + i));
      end
      drive(0, 0, 0, 8'h00, 1);
      tick();
    end
    drive(0, 0, 0, 8'h00, 0);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got %b want 0", out_valid); end
    drive(1, 1, 1, 8'h80, 0);
    tick();
    drive(0, 0, 0, 8'h00, 0);
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", overflow); end
  endtask

  task automatic test_full_overflow_status();
    logic [7:0] v;
    for (int i = 0; i < 17; i++) begin
      drive(1, 0, 1, 8'(8'h30 + i), 0);
      tick();
    end
    drive(0, 0, 0, 8'h00, 0);
    rd(1, v);
    n_tests++; if (v !== 8'h90) begin n_fail++; $display("FAIL full17_status got %h want 90", v); end
    n_tests++; if (out_data !== 7'h30) begin n_fail++; $display("FAIL full17_head got %h want 30", out_data); end
  endtask

  task automatic test_flush();
    logic [7:0] v;
    // Queue is full with overflow set; drain down to 5 entries
    repeat (11) begin
      drive(0, 0, 0, 8'h00, 1);
      tick();
    end
    drive(0, 0, 0, 8'h00, 0);
    rd(1, v);
    n_tests++; if (v !== 8'h85) begin n_fail++; $display("FAIL flush_pre got %h want 85", v); end
    drive(1, 1, 1, 8'h81, 1);
    tick();
    drive(0, 0, 0, 8'h00, 1);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", out_valid); end
    rd(1, v);
    n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL flush_status got %h want 00", v); end
    tick();
    rd(1, v);
    n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL flush_nopop got %h want 00", v); end
    drive(0, 0, 0, 8'h00, 0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    logic [6:0] ch;
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 1, 8'($urandom_range(0, 255)), 0);
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      ch = 7'($urandom_range(0, 127));
      drive(1, 0, 1, {1'b1, ch}, 1);
      n_tests++;
      if (out_data !== mq[0]) begin n_fail++; $display("FAIL steady_data_%0d got %h want %h", i, out_data, mq[0]); end
      tick();
      rd(1, v);
      n_tests++;
      if (v !== 8'h08) begin n_fail++; $display("FAIL steady_count_%0d got %h want 08", i, v); end
    end
    drive(1, 1, 1, 8'h01, 0);
    tick();
    drive(0, 0, 0, 8'h00, 0);
  endtask

  task automatic test_async_reset();
    logic [7:0] v;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 8'(8'h61 + i), 0);
      tick();
    end
    drive(0, 0, 0, 8'h00, 0);
    #10 rst = 1'b1;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid got %b want 0", out_valid); end
    rd(1, v);
    n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL arst_count got %h want 00", v); end
    mq.delete(); m_ovf = 1'b0;
    #3 rst = 1'b0;
    drive(1, 0, 1, 8'h0D, 0);
    tick();
    drive(0, 0, 0, 8'h00, 0);
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 7'h0D) begin
      n_fail++; $display("FAIL arst_after got %h/%b want 0d/1", out_data, out_valid);
    end
    drive(0, 0, 0, 8'h00, 1);
    tick();
    drive(0, 0, 0, 8'h00, 0);
  endtask

  task automatic test_random();
    logic       en, adr, we, rdy;
    logic [7:0] d, exp_dout;
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 3) != 0);
      adr = ($urandom_range(0, 15) == 0);
      we  = ($urandom_range(0, 2) != 0);
      rdy = ($urandom_range(0, 2) == 0);
      d   = 8'($urandom);
      if (adr && we && $urandom_range(0, 3) != 0) d[0] = 1'b0;
      drive(en, adr, we, d, rdy);
      #1;
      exp_dout = 8'h00;
      if (en && !we) begin
        if (adr) exp_dout = {m_ovf, 2'b00, 5'(mq.size())};
        else     exp_dout = {(mq.size() == DEPTH), 7'b0};
      end
      n_tests++;
      if (out_valid !== (mq.size() != 0) || overflow !== m_ovf || dout !== exp_dout) begin
        n_fail++;
        $display("FAIL rand_state_%0d got v%b o%b d%h want v%b o%b d%h", i,
                 out_valid, overflow, dout, (mq.size() != 0), m_ovf, exp_dout);
      end
      if (mq.size() != 0) begin
        n_tests++;
        if (out_data !== mq[0]) begin n_fail++; $display("FAIL rand_data_%0d got %h want %h", i, out_data, mq[0]); end
      end
      tick();
    end
    drive(0, 0, 0, 8'h00, 0);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 8'h00, 0);
    test_reset();
    test_single();
    test_full();
    test_full_overflow_status();
    test_flush();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
